mac_writeback: RTL and testbench

Output writeback stage that sits directly downstream of the 3-tap pipelined MAC. It accepts finished accumulator results tagged with their output index, then applies optional ReLU and signed saturation. Results are buffered in a small FIFO so the MAC pipeline can be back-pressured through its `input_valid` enable, and are written to output memory over a valid/ready port. A start/done job interface counts the expected results and signals completion once the last write has been accepted.

---
 rtl/mac_writeback_pkg.sv | 38 +++
 rtl/wb_fifo.sv | 57 +++++
 rtl/mac_writeback.sv | 137 +++++++++++++
 tb/tb_mac_writeback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_writeback_pkg.sv
// Shared types and helpers for the MAC writeback stage.
//   wb_state_t : job FSM states
//   wb_entry_t : one buffered memory write (address + processed data)
//   sat_relu() : optional ReLU followed by signed saturation to out_w bits
package mac_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // Fields sized for the widest supported configuration (32-bit address,
  // 32-bit data); the top narrows them back to ADDR_WIDTH / OUT_WIDTH.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic signed [31:0] sat_relu(
    input logic signed [31:0] v,
    input logic               relu,
    input int unsigned        out_w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    r  = v;
    if (relu && (r < 32'sd0)) r = 32'sd0;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result buffer between the MAC and the output memory port.
// Ports:
//   clk, rst_in      : clock, synchronous active-high reset
//   push, din        : write din at the tail (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head             : current head entry
//   full, empty      : occupancy flags
//   count            : number of entries held
module wb_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared on reset so the memory port reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mac_writeback.sv
// Writeback stage behind the 3-tap MAC: ReLU/saturate each result, buffer it,
// and write it to output memory over valid/ready. A start/done job interface
// counts total_count results and pulses done after the last write is taken.
// Ports:
//   clk, rst_in                      : clock, synchronous active-high reset
//   start, base_addr, total_count,
//   relu_en                          : job launch and config (sampled in IDLE)
//   mac_valid, mac_ready, mac_out,
//   mac_ch                           : result input, mac_ready gates the MAC
//   mem_valid, mem_ready, mem_addr,
//   mem_wdata                        : memory write port
//   busy, done                       : job status
//
// state | meaning
// IDLE  | waiting for start; config registers hold last job
// RUN   | accepting results until total_count have been taken
// DRAIN | no more accepts; emptying the FIFO to memory
// DONE  | one-cycle completion pulse on done
module mac_writeback
  import mac_writeback_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [31:0]                 total_count,
  input  logic                        relu_en,
  input  logic                        mac_valid,
  output logic                        mac_ready,
  input  logic signed [IN_WIDTH-1:0]  mac_out,
  input  logic [31:0]                 mac_ch,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [OUT_WIDTH-1:0]        mem_wdata,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_state_t             state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           total_q;
  logic [31:0]           accepted_q;
  logic                  relu_q;
  logic                  done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  logic                  accept;
  logic                  pop;
  logic                  last_accept;
  logic                  drain_done;

  // The count gate keeps a zero-length job from taking anything during its
  // single RUN cycle; it depends on registers only, never on mem_ready.
  assign mac_ready   = (state_q == RUN) && !fifo_full && (accepted_q != total_q);
  assign accept      = mac_valid && mac_ready;
  assign mem_valid   = !fifo_empty;
  assign pop         = mem_valid && mem_ready;
  assign last_accept = accept && ((accepted_q + 32'd1) == total_q);
  // Look ahead to the FIFO state after this edge so done follows the last
  // write by exactly one cycle.
  assign drain_done  = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

  assign mem_addr  = ADDR_WIDTH'(head_entry.addr);
  assign mem_wdata = OUT_WIDTH'(head_entry.data);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = 32'(base_q + ADDR_WIDTH'(mac_ch));
    push_entry.data = sat_relu(32'(mac_out), relu_q, OUT_WIDTH);
  end

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_in (rst_in),
    .push   (accept),
    .din    (push_entry),
    .pop    (pop),
    .head   (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= IDLE;
      base_q     <= '0;
      total_q    <= '0;
      relu_q     <= 1'b0;
      accepted_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) accepted_q <= accepted_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            total_q    <= total_count;
            relu_q     <= relu_en;
            accepted_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (last_accept || (accepted_q == total_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_writeback.sv
module tb_mac_writeback;

  logic              clk = 1'b0;
  logic              rst_in;
  logic              start;
  logic [15:0]       base_addr;
  logic [31:0]       total_count;
  logic              relu_en;
  logic              mac_valid;
  logic              mac_ready;
  logic signed [15:0] mac_out;
  logic [31:0]       mac_ch;
  logic              mem_valid;
  logic              mem_ready;
  logic [15:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [23:0] wq[$];
  bit tog_run;

  mac_writeback #(
    .IN_WIDTH(16), .OUT_WIDTH(8), .ADDR_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .base_addr(base_addr),
    .total_count(total_count), .relu_en(relu_en), .mac_valid(mac_valid),
    .mac_ready(mac_ready), .mac_out(mac_out), .mac_ch(mac_ch),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Log every accepted memory write and every done cycle.
  always @(posedge clk) begin
    if (!rst_in && mem_valid && mem_ready) wq.push_back({mem_addr, mem_wdata});
    if (!rst_in && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [15:0] ea, input logic [7:0] ed);
    logic [23:0] w;
    if (wq.size() > 0) w = wq.pop_front();
    else w = 'x;
    chk({tag, "_addr"}, 64'(w[23:8]), 64'(ea));
    chk({tag, "_data"}, 64'(w[7:0]), 64'(ed));
  endtask

  task automatic start_job(input logic [15:0] b, input int cnt, input logic r);
    start = 1'b1; base_addr = b; total_count = cnt; relu_en = r;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send(input int ch, input int val);
    int n = 0;
    mac_valid = 1'b1; mac_ch = ch; mac_out = val[15:0];
    while (!mac_ready && n < 100) begin tick(); n++; end
    chk("send_ready", 64'(mac_ready), 64'd1);
    tick();
    mac_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin tick(); n++; end
    chk("done_seen", 64'(done), 64'd1);
    tick();
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mac_ready"}, 64'(mac_ready), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  initial begin
    int dc;
    rst_in = 1'b1; start = 1'b0; base_addr = '0; total_count = '0; relu_en = 1'b0;
    mac_valid = 1'b0; mac_out = '0; mac_ch = '0; mem_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_in = 1'b0;
    tick();

    // Basic path with exact done timing.
    mem_ready = 1'b1;
    start_job(16'h0100, 3, 1'b0);
    send(0, 5); send(1, -7); send(2, 300);
    chk("basic_ready_after_last", 64'(mac_ready), 64'd0);
    tick();
    chk("basic_done_pulse", 64'(done), 64'd1);
    chk("basic_nwrites", 64'(wq.size()), 64'd3);
    tick();
    chk("basic_done_low", 64'(done), 64'd0);
    chk("basic_idle", 64'(busy), 64'd0);
    check_write("basic0", 16'h0100, 8'h05);
    check_write("basic1", 16'h0101, 8'hF9);
    check_write("basic2", 16'h0102, 8'h7F);

    // ReLU and saturation.
    start_job(16'h0000, 4, 1'b1);
    send(0, -1); send(1, -32768); send(2, 128); send(3, 127);
    wait_done(20);
    check_write("relu0", 16'h0000, 8'h00);
    check_write("relu1", 16'h0001, 8'h00);
    check_write("relu2", 16'h0002, 8'h7F);
    check_write("relu3", 16'h0003, 8'h7F);
    start_job(16'h0010, 2, 1'b0);
    send(0, -129); send(1, -128);
    wait_done(20);
    check_write("satneg0", 16'h0010, 8'h80);
    check_write("satneg1", 16'h0011, 8'h80);

    // Back-pressure: fill the FIFO, stall, then release.
    mem_ready = 1'b0;
    start_job(16'h0200, 6, 1'b0);
    for (int i = 0; i < 4; i++) send(i, 10 + i);
    chk("bp_ready_low_full", 64'(mac_ready), 64'd0);
    mac_valid = 1'b1; mac_ch = 4; mac_out = 16'sd14;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready_stall", 64'(mac_ready), 64'd0);
      chk("bp_valid_stable", 64'(mem_valid), 64'd1);
      chk("bp_addr_stable", 64'(mem_addr), 64'h0200);
      chk("bp_data_stable", 64'(mem_wdata), 64'd10);
    end
    mem_ready = 1'b1;
    send(4, 14); send(5, 15);
    wait_done(30);
    chk("bp_nwrites", 64'(wq.size()), 64'd6);
    for (int i = 0; i < 6; i++) check_write("bp", 16'(16'h0200 + i), 8'(10 + i));

    // Address wrap and zero-length job.
    start_job(16'hFFFF, 1, 1'b0);
    send(2, 1);
    wait_done(20);
    check_write("wrap", 16'h0001, 8'h01);
    dc = done_cnt;
    start_job(16'h0000, 0, 1'b0);
    chk("zero_ready_low", 64'(mac_ready), 64'd0);
    wait_done(20);
    chk("zero_nwrites", 64'(wq.size()), 64'd0);
    chk("zero_one_done", 64'(done_cnt - dc), 64'd1);

    // start while busy is ignored.
    start_job(16'h0300, 2, 1'b0);
    start = 1'b1; base_addr = 16'h0500; total_count = 5; relu_en = 1'b1;
    tick();
    start = 1'b0;
    send(0, -3); send(1, 4);
    wait_done(20);
    check_write("busystart0", 16'h0300, 8'hFD);
    check_write("busystart1", 16'h0301, 8'h04);

    // mac_valid in IDLE is not taken.
    mac_valid = 1'b1; mac_ch = 0; mac_out = 16'sd9;
    tick();
    chk("idle_ready", 64'(mac_ready), 64'd0);
    tick();
    chk("idle_no_valid", 64'(mem_valid), 64'd0);
    mac_valid = 1'b0;
    chk("idle_nwrites", 64'(wq.size()), 64'd0);

    // Random mem_ready keeps order.
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin
          @(posedge clk); #1;
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    start_job(16'h0400, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(i, i * 3 - 10);
    wait_done(200);
    tog_run = 1'b0;
    tick(); tick();
    mem_ready = 1'b1;
    chk("rand_nwrites", 64'(wq.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      int v;
      v = i * 3 - 10;
      check_write("rand", 16'(16'h0400 + i), v[7:0]);
    end

    // Reset mid-job with two entries queued.
    mem_ready = 1'b0;
    start_job(16'h0600, 5, 1'b0);
    send(0, 1); send(1, 2);
    chk("midrst_queued", 64'(mem_valid), 64'd1);
    rst_in = 1'b1;
    tick();
    check_all_zero("midrst");
    rst_in = 1'b0;
    mem_ready = 1'b1;
    dc = done_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_no_valid", 64'(mem_valid), 64'd0);
    chk("midrst_nwrites", 64'(wq.size()), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
